// File: rtl/cpu_pkg.sv
// Shared fetch-path constants and types for the instruction-fetch stage.
package cpu_pkg;
  localparam int INS_W  = 32;
  localparam int ADDR_W = 32;

  localparam logic [INS_W-1:0] NOP_INS = 32'h0;

  localparam int IFCTRL_VALID  = 34;
  localparam int IFCTRL_BRANCH = 33;
  localparam int IFCTRL_STOP   = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [INS_W-1:0]  ins;
  } fetch_ent_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
  endfunction
endpackage

// File: rtl/if_fetch_fifo.sv
// In-order fetch buffer holding {addr, ins}; flush clears it in one cycle.
module if_fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  fetch_ent_t wdata_i,
  input  logic       pop_i,
  input  logic       flush_i,
  output fetch_ent_t rdata_o,
  output logic [AW:0] count_o,
  output logic       empty_o,
  output logic       full_o
);
  fetch_ent_t      mem_q [DEPTH];
  logic [AW-1:0]   wp_q, rp_q;
  logic [AW:0]     cnt_q;

  assign rdata_o = mem_q[rp_q];
  assign count_o = cnt_q;
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wp_q <= wp_q + AW'(1);
      if (pop_i)  rp_q <= rp_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once counted valid.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wp_q] <= wdata_i;
  end
endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, keeps imem busy, feeds decode one word per cycle.
// Optional perf counters are built with `define IF_PERF_CNT_EN.
module if_stage
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int FIFO_DEPTH      = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              delay,
  input  logic [34:0]       IFControl,
  output logic [INS_W-1:0]  ins,
  output logic [ADDR_W-1:0] if_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [INS_W-1:0]  imem_rdata
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_bubble_cnt,
  output logic [31:0]       perf_flush_cnt
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  logic [ADDR_W-1:0] pc_q, pc_d, if_pc_q, if_pc_d, rsp_addr_q, rsp_addr_d;
  logic [INS_W-1:0]  ins_q, ins_d;
  logic [OW-1:0]     outst_q, outst_d, drop_q, drop_d;
  logic              run_q;

  logic              stop_req, redirect, advance, accept, rsp_live;
  logic              fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [CW-1:0]     fifo_cnt;
  fetch_ent_t        fifo_head;

  // Stop only counts alongside branch, so it never widens the redirect condition.
  assign stop_req = IFControl[IFCTRL_STOP] & IFControl[IFCTRL_BRANCH];
  assign redirect = !delay && (IFControl[IFCTRL_BRANCH] || stop_req);
  assign advance  = !delay && IFControl[IFCTRL_VALID] && !IFControl[IFCTRL_BRANCH];

  assign imem_req  = run_q && !delay && !redirect
                   && (int'(outst_q) < MAX_OUTSTANDING)
                   && (int'(fifo_cnt) + int'(outst_q) < FIFO_DEPTH);
  assign imem_addr = pc_q;
  assign accept    = imem_req && imem_ready;

  assign rsp_live  = imem_rvalid && (drop_q == '0);
  assign fifo_pop  = advance && !fifo_empty;
  assign fifo_push = rsp_live && !redirect && !(advance && fifo_empty);

  assign ins   = ins_q;
  assign if_pc = if_pc_q;

  if_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .push_i  (fifo_push),
    .wdata_i ('{addr: rsp_addr_q, ins: imem_rdata}),
    .pop_i   (fifo_pop),
    .flush_i (redirect),
    .rdata_o (fifo_head),
    .count_o (fifo_cnt),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  always_comb begin
    pc_d       = pc_q;
    ins_d      = ins_q;
    if_pc_d    = if_pc_q;
    rsp_addr_d = rsp_addr_q;
    outst_d    = outst_q + OW'(accept) - OW'(imem_rvalid);
    drop_d     = drop_q;
    if (imem_rvalid && drop_q != '0) drop_d = drop_q - OW'(1);
    if (redirect) begin
      pc_d       = IFControl[ADDR_W-1:0];
      rsp_addr_d = IFControl[ADDR_W-1:0];
      ins_d      = NOP_INS;
      drop_d     = outst_q - OW'(imem_rvalid);
    end else begin
      if (accept)   pc_d       = pc_q + 32'd1;
      if (rsp_live) rsp_addr_d = rsp_addr_q + 32'd1;
      if (advance) begin
        if (!fifo_empty) begin
          ins_d   = fifo_head.ins;
          if_pc_d = fifo_head.addr;
        end else if (rsp_live) begin
          ins_d   = imem_rdata;
          if_pc_d = rsp_addr_q;
        end else begin
          ins_d   = NOP_INS;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q       <= RESET_PC;
      rsp_addr_q <= RESET_PC;
      ins_q      <= NOP_INS;
      if_pc_q    <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
      run_q      <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      rsp_addr_q <= rsp_addr_d;
      ins_q      <= ins_d;
      if_pc_q    <= if_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      run_q      <= 1'b1;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(fifo_push && fifo_full && !fifo_pop));

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, bubble_cnt_q, flush_cnt_q;
  logic        delivered;
  assign delivered = !fifo_empty || rsp_live;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      fetch_cnt_q  <= sat_inc(fetch_cnt_q,  advance && delivered);
      bubble_cnt_q <= sat_inc(bubble_cnt_q, advance && !delivered);
      flush_cnt_q  <= sat_inc(flush_cnt_q,  redirect);
    end
  end

  assign perf_fetch_cnt  = fetch_cnt_q;
  assign perf_bubble_cnt = bubble_cnt_q;
  assign perf_flush_cnt  = flush_cnt_q;
`endif
endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage directly upstream of the decode stage. Owns the PC and issues word fetches to instruction memory.
- Buffers returned words in a small in-order FIFO and presents one instruction per cycle on `ins`.
- Obeys the 35-bit `IFControl` bus from decode: advance, stall, branch redirect and flush.
- Emits NOP (32'h0, opcode 0000) whenever it has no valid instruction.

Parameters:
- RESET_PC, 32'h0, PC loaded on reset (word address).
- FIFO_DEPTH, 2, fetch-buffer entries (power of 2, >=2).
- MAX_OUTSTANDING, 2, maximum in-flight imem requests.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- delay  in  1  global freeze, same meaning as in the other stages.
- IFControl  in  35  from decode: [34] valid/advance, [33] branch, [32] stop, [31:0] target.
- ins  out  32  instruction to decode, registered.
- if_pc  out  32  PC of the word currently on `ins` (debug).
- imem_req  out  1  fetch request.
- imem_addr  out  32  word address of the request.
- imem_ready  in  1  memory accepts the request this cycle when req&ready.
- imem_rvalid  in  1  response valid. Responses arrive in order, latency >=1, cannot be back-pressured.
- imem_rdata  in  32  response word.

Behaviour:
- Reset (async, reset_n=0):
  - pc=RESET_PC; ins=32'h0; if_pc=0; imem_req=0.
  - FIFO empty; outstanding=0; drop=0.
- Word addressing: the PC increments by 1 per accepted request, wrapping at 2^32. Branch target = IFControl[31:0] verbatim.
- Issue rule: `imem_req=1` when all hold:
  - delay=0;
  - no redirect this cycle;
  - outstanding < MAX_OUTSTANDING;
  - fifo_count + outstanding < FIFO_DEPTH.
  - `imem_addr`=pc. On req&ready: pc+=1, outstanding+=1.
- Response handling is always active, including while delay=1, since responses are never back-pressured:
  - Each rvalid decrements outstanding.
  - If drop>0: discard the word, drop-=1.
  - Otherwise the word is written to the FIFO, or bypassed (see Advance).
- Redirect (IFControl[33]=1, delay=0), taken regardless of bit 34:
  - pc=target.
  - FIFO flushed.
  - drop = outstanding minus any response accepted this cycle; that response is also discarded.
  - ins=32'h0 next cycle.
  - No request is issued in the redirect cycle; the first request to the target goes out the following cycle.
- Advance (IFControl[34]=1, [33]=0, delay=0):
  - FIFO non-empty: ins<=head, pop.
  - FIFO empty with a live rvalid: ins<=imem_rdata (bypass, 1-cycle latency from response to ins).
  - Otherwise: ins<=32'h0.
  - if_pc tracks the address of the word placed on ins, carried with each FIFO entry.
- Stall (IFControl[34]=0, [33]=0): ins and if_pc hold. FIFO may still fill from responses.
- Stop bit [32]: asserted only with branch; treated as branch. Stop with branch=0 is ignored.
- delay=1: pc, ins, if_pc and the FIFO read side frozen; no new requests; responses still captured per the rules above.
- Simultaneous events:
  - Push and pop in the same cycle are legal at any fill level.
  - Redirect takes priority over advance and over a same-cycle push.
- Full FIFO: impossible to overflow, by the issue rule. Writing when full is an assertion failure.

Optional Feature:
- IF_PERF_CNT_EN: adds outputs perf_fetch_cnt[31:0], perf_bubble_cnt[31:0], perf_flush_cnt[31:0].
  - perf_fetch_cnt: words delivered to ins.
  - perf_bubble_cnt: advances that produced NOP.
  - perf_flush_cnt: redirects.
  - All reset to 0, saturate at 32'hFFFFFFFF, frozen by delay.
- Without the macro: the ports and logic are absent; the rest of the behaviour is identical.

Decomposition:
- Shared package (cpu_pkg):
  - NOP_INS=32'h0;
  - IFCTRL_VALID=34, IFCTRL_BRANCH=33, IFCTRL_STOP=32 bit indices;
  - INS_W=32, ADDR_W=32.
- Sub-module if_fetch_fifo: parameterised sync FIFO holding {addr, ins}, with push, pop, flush, count, empty, full.

Test Plan:
- Reset with RESET_PC=0, memory latency 1, ready=1, IFControl=35'h4_0000_0000 -> requests addr 0,1,2…; ins shows mem[0] in the 3rd cycle after reset release, then one word per cycle; if_pc 0,1,2.
- Stall: hold bit34=0 for 4 cycles -> ins constant; at most 2 requests outstanding+buffered; after release, words continue with no gap or duplicate.
- Branch: 2 requests in flight, IFControl={1,1,1,32'h40} -> ins=0 next cycle; both old responses dropped; next request addr 0x40; mem[0x40] is the first non-NOP word.
- Redirect in the same cycle as rvalid -> that word is discarded, drop counts the remaining in-flight request, no stale word reaches ins.
- delay=1 for 3 cycles while a response arrives -> no requests, ins frozen, the word is kept in the FIFO and delivered after delay drops.
- Async reset asserted mid-stream, between clock edges -> ins=0 and imem_req=0 immediately; the fetch restarts at RESET_PC.
